// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: state encoding, ACK/NACK levels,
// bit counter width and default address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX,
    ST_RX_ACK,
    ST_TX,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int                    BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0]  CNT_LAST  = 4'd7;
  localparam logic [BIT_CNT_W-1:0]  CNT_BYTE  = 4'd8;
  localparam logic [BIT_CNT_W-1:0]  CNT_ONE   = 4'd1;

  localparam logic [6:0] DEFAULT_ADDR = 7'h42;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer, optional 3-sample stability filter and rise/fall
// strobes for one bus line. Filter enabled by defining SLAVE_GLITCH_FILTER_EN.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_line,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       w_level;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_line};
  end

`ifdef SLAVE_GLITCH_FILTER_EN
  logic [1:0] r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_hist <= 2'b11;
    else          r_hist <= {r_hist[0], r_sync[1]};
  end

  // r_prev doubles as the held filter output
  always_comb begin
    w_level = r_prev;
    if ((r_hist[0] == r_sync[1]) && (r_hist[1] == r_sync[1])) w_level = r_sync[1];
  end
`else
  assign w_level = r_sync[1];
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b1;
    else          r_prev <= w_level;
  end

  assign o_level = w_level;
  assign o_rise  = w_level & ~r_prev;
  assign o_fall  = ~w_level & r_prev;

endmodule

// File: rtl/slave_device.sv
// I2C target: START/STOP detection, 7-bit address match, byte receive and
// transmit with ACK handling. Line filter selected by SLAVE_GLITCH_FILTER_EN.
//
// state       | meaning
// ST_IDLE     | bus free, waiting for START
// ST_ADDR     | shifting address byte (bit 0 = R/W)
// ST_ADDR_ACK | driving address ACK for one SCL period
// ST_RX       | shifting a written data byte
// ST_RX_ACK   | ACK/NACK slot after a written byte
// ST_TX       | shifting out a read data byte
// ST_TX_ACK   | sampling master ACK/NACK
// ST_IGNORE   | not addressed, waiting for START/STOP
module slave_device
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS = DEFAULT_ADDR
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_tx_data,
  input  logic       i_rx_nack,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  output logic       o_tx_req,
  output logic       o_rw,
  output logic       o_busy,
  input  logic       io_scl,
  inout  wire        io_sda
);

  logic w_scl_level, w_scl_rise, w_scl_fall;
  logic w_sda_level, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_sync u_scl_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_line(io_scl),
    .o_level(w_scl_level), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_line(io_sda),
    .o_level(w_sda_level), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl_level;
  assign w_stop  = w_sda_rise & w_scl_level;

  state_t               r_state, w_state;
  logic [BIT_CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]           r_shift, w_shift, w_byte;
  logic [7:0]           r_rx_data, w_rx_data;
  logic                 r_sda_low, w_sda_low;
  logic                 r_rx_valid, w_rx_valid;
  logic                 r_tx_req, w_tx_req;
  logic                 r_rw, w_rw;
  logic                 r_busy, w_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rx_data  <= '0;
      r_sda_low  <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_shift    <= w_shift;
      r_rx_data  <= w_rx_data;
      r_sda_low  <= w_sda_low;
      r_rx_valid <= w_rx_valid;
      r_tx_req   <= w_tx_req;
      r_rw       <= w_rw;
      r_busy     <= w_busy;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_shift    = r_shift;
    w_rx_data  = r_rx_data;
    w_sda_low  = r_sda_low;
    w_rx_valid = 1'b0;
    w_tx_req   = 1'b0;
    w_rw       = r_rw;
    w_busy     = r_busy;
    w_byte     = {r_shift[6:0], w_sda_level};

    if (w_stop) begin
      w_state   = ST_IDLE;
      w_sda_low = 1'b0;
      w_cnt     = '0;
      w_busy    = 1'b0;
    end else if (w_start) begin
      w_state   = ST_ADDR;
      w_sda_low = 1'b0;
      w_cnt     = '0;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_rise) begin
          w_shift = w_byte;
          w_cnt   = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_cnt = '0;
            if (w_byte[7:1] == ADDRESS) begin
              w_state = ST_ADDR_ACK;
              w_rw    = w_byte[0];
              w_busy  = 1'b1;
            end else begin
              w_state = ST_IGNORE;
              w_busy  = 1'b0;
            end
          end
        end
        // r_cnt marks whether the ACK slot has been opened
        ST_ADDR_ACK: if (w_scl_fall) begin
          if (r_cnt == '0) begin
            w_sda_low = 1'b1;
            w_cnt     = CNT_ONE;
          end else if (r_rw) begin
            w_state   = ST_TX;
            w_tx_req  = 1'b1;
            w_shift   = i_tx_data;
            w_sda_low = ~i_tx_data[7];
            w_cnt     = '0;
          end else begin
            w_state   = ST_RX;
            w_sda_low = 1'b0;
            w_cnt     = '0;
          end
        end
        ST_RX: if (w_scl_rise) begin
          w_shift = w_byte;
          w_cnt   = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_rx_data  = w_byte;
            w_rx_valid = 1'b1;
            w_state    = ST_RX_ACK;
            w_cnt      = '0;
          end
        end
        ST_RX_ACK: if (w_scl_fall) begin
          if (r_cnt == '0) begin
            w_sda_low = ((i_rx_nack ? NACK : ACK) == 1'b0);
            w_cnt     = CNT_ONE;
          end else begin
            w_sda_low = 1'b0;
            w_cnt     = '0;
            w_state   = ST_RX;
          end
        end
        ST_TX: begin
          if (w_scl_rise) begin
            w_cnt = r_cnt + CNT_ONE;
          end else if (w_scl_fall) begin
            if (r_cnt == CNT_BYTE) begin
              w_sda_low = 1'b0;
              w_cnt     = '0;
              w_state   = ST_TX_ACK;
            end else begin
              w_shift   = {r_shift[6:0], 1'b0};
              w_sda_low = ~r_shift[6];
            end
          end
        end
        ST_TX_ACK: begin
          if (w_scl_rise) begin
            if (w_sda_level == NACK) begin
              w_state = ST_IGNORE;
              w_busy  = 1'b0;
            end else begin
              w_cnt = CNT_ONE;
            end
          end else if (w_scl_fall && (r_cnt != '0)) begin
            w_state   = ST_TX;
            w_tx_req  = 1'b1;
            w_shift   = i_tx_data;
            w_sda_low = ~i_tx_data[7];
            w_cnt     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_sda     = r_sda_low ? 1'b0 : 1'bz;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_tx_req   = r_tx_req;
  assign o_rw       = r_rw;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_slave_device.sv
// Bench for slave_device: bit-banged I2C master, directed cases plus
// randomized transactions checked against a transaction-level model.
module tb_slave_device;

  logic       i_clk     = 1'b0;
  logic       i_rst_n   = 1'b0;
  logic       i_rx_nack = 1'b0;
  logic [7:0] i_tx_data = 8'h00;
  logic       m_scl     = 1'b1;
  logic       m_sda_low = 1'b0;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, o_tx_req, o_rw, o_busy;
  wire        w_sda;

  int n_checks  = 0;
  int n_errors  = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;
  int drove_cnt = 0;

  pullup (w_sda);
  assign w_sda = m_sda_low ? 1'b0 : 1'bz;

  slave_device dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_tx_data (i_tx_data),
    .i_rx_nack (i_rx_nack),
    .o_rx_data (o_rx_data),
    .o_rx_valid(o_rx_valid),
    .o_tx_req  (o_tx_req),
    .o_rw      (o_rw),
    .o_busy    (o_busy),
    .io_scl    (m_scl),
    .io_sda    (w_sda)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (o_rx_valid === 1'b1) rx_pulses <= rx_pulses + 1;
    if (o_tx_req === 1'b1)   tx_pulses <= tx_pulses + 1;
    if (!m_sda_low && (w_sda === 1'b0)) drove_cnt <= drove_cnt + 1;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SCL period starting and ending mid-low; returns SDA seen mid-high.
  task automatic clk_bit(input logic v, output logic s);
    m_sda_low = ~v;
    wait_cyc(5);
    m_scl = 1'b1;
    wait_cyc(5);
    s = w_sda;
    wait_cyc(5);
    m_scl = 1'b0;
    wait_cyc(5);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b1;
    wait_cyc(10);
    m_scl = 1'b0;
    wait_cyc(5);
  endtask

  task automatic i2c_rstart();
    m_sda_low = 1'b0;
    wait_cyc(5);
    m_scl = 1'b1;
    wait_cyc(10);
    m_sda_low = 1'b1;
    wait_cyc(10);
    m_scl = 1'b0;
    wait_cyc(5);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_cyc(5);
    m_scl = 1'b1;
    wait_cyc(10);
    m_sda_low = 1'b0;
    wait_cyc(10);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      b[i] = s;
    end
    clk_bit(nack, s);
  endtask

  initial begin
    logic       ack, s;
    logic [7:0] d;
    logic [7:0] exp_rx;
    int         rx0, tx0, drv0;

    // reset
    wait_cyc(3);
    check("rst_rx_data", o_rx_data, 8'h00);
    check("rst_rx_valid", o_rx_valid, 1'b0);
    check("rst_tx_req", o_tx_req, 1'b0);
    check("rst_rw", o_rw, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_sda", w_sda, 1'b1);
    i_rst_n = 1'b1;
    wait_cyc(5);

    // write 0xA5 to 0x42
    rx0 = rx_pulses;
    i2c_start();
    write_byte(8'h84, ack);
    check("wr_addr_ack", ack, 1'b0);
    check("wr_rw", o_rw, 1'b0);
    check("wr_busy", o_busy, 1'b1);
    write_byte(8'hA5, ack);
    check("wr_data_ack", ack, 1'b0);
    check("wr_rx_data", o_rx_data, 8'hA5);
    check("wr_rx_pulses", rx_pulses - rx0, 1);
    check("wr_busy_pre_stop", o_busy, 1'b1);
    i2c_stop();
    check("wr_busy_post_stop", o_busy, 1'b0);
    exp_rx = 8'hA5;

    // read 0x3C with master NACK
    tx0 = tx_pulses;
    i_tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h85, ack);
    check("rd_addr_ack", ack, 1'b0);
    check("rd_rw", o_rw, 1'b1);
    read_byte(1'b1, d);
    check("rd_data", d, 8'h3C);
    check("rd_tx_pulses", tx_pulses - tx0, 1);
    check("rd_busy_after_nack", o_busy, 1'b0);
    check("rd_sda_released", w_sda, 1'b1);
    i2c_stop();

    // non-matching address
    rx0 = rx_pulses;
    drv0 = drove_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("miss_addr_nack", ack, 1'b1);
    write_byte(8'h0F, ack);
    check("miss_data_nack", ack, 1'b1);
    check("miss_busy", o_busy, 1'b0);
    i2c_stop();
    check("miss_no_drive", drove_cnt - drv0, 0);
    check("miss_no_rx", rx_pulses - rx0, 0);

    // data NACK requested by local logic
    rx0 = rx_pulses;
    i2c_start();
    write_byte(8'h84, ack);
    check("nk_addr_ack", ack, 1'b0);
    i_rx_nack = 1'b1;
    write_byte(8'h69, ack);
    i_rx_nack = 1'b0;
    check("nk_data_nack", ack, 1'b1);
    check("nk_rx_data", o_rx_data, 8'h69);
    check("nk_rx_pulses", rx_pulses - rx0, 1);
    i2c_stop();
    exp_rx = 8'h69;

    // repeated START after a partial byte
    rx0 = rx_pulses;
    i_tx_data = 8'hC3;
    i2c_start();
    write_byte(8'h84, ack);
    check("rs_addr1_ack", ack, 1'b0);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    clk_bit(1'b1, s);
    i2c_rstart();
    write_byte(8'h85, ack);
    check("rs_addr2_ack", ack, 1'b0);
    check("rs_rw", o_rw, 1'b1);
    check("rs_busy", o_busy, 1'b1);
    read_byte(1'b1, d);
    check("rs_rd_data", d, 8'hC3);
    i2c_stop();
    check("rs_no_rx", rx_pulses - rx0, 0);
    check("rs_rx_data_kept", o_rx_data, exp_rx);

    // randomized transactions against a transaction-level model
    for (int t = 0; t < 12; t++) begin
      logic [6:0] a;
      logic       rw, match;
      int         nb;
      a      = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h42;
      rw     = 1'($urandom_range(0, 1));
      nb     = $urandom_range(1, 3);
      match  = (a == 7'h42);
      i_tx_data = 8'($urandom);
      rx0 = rx_pulses;
      tx0 = tx_pulses;
      i2c_start();
      write_byte({a, rw}, ack);
      check("rnd_addr_ack", ack, match ? 1'b0 : 1'b1);
      for (int k = 0; k < nb; k++) begin
        if (!rw) begin
          d = 8'($urandom);
          i_rx_nack = 1'($urandom_range(0, 1));
          write_byte(d, ack);
          check("rnd_wr_ack", ack, (match && !i_rx_nack) ? 1'b0 : 1'b1);
          if (match) exp_rx = d;
          i_rx_nack = 1'b0;
        end else begin
          read_byte(k == nb - 1, d);
          check("rnd_rd_data", d, match ? i_tx_data : 8'hFF);
        end
      end
      i2c_stop();
      check("rnd_rx_pulses", rx_pulses - rx0, (match && !rw) ? nb : 0);
      check("rnd_tx_pulses", tx_pulses - tx0, (match && rw) ? nb : 0);
      check("rnd_rx_data", o_rx_data, exp_rx);
      check("rnd_busy", o_busy, 1'b0);
    end

    // async reset while the address ACK is being driven
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h11, ack);
    i2c_rstart();
    for (int i = 7; i >= 0; i--) clk_bit(((8'h85 >> i) & 8'h01) != 8'h00, s);
    m_sda_low = 1'b0;
    wait_cyc(5);
    m_scl = 1'b1;
    wait_cyc(3);
    check("ra_ack_driven", w_sda, 1'b0);
    check("ra_rw_before", o_rw, 1'b1);
    #2 i_rst_n = 1'b0;
    #1;
    check("ra_sda_released", w_sda, 1'b1);
    check("ra_busy", o_busy, 1'b0);
    check("ra_rw", o_rw, 1'b0);
    check("ra_rx_data", o_rx_data, 8'h00);
    check("ra_rx_valid", o_rx_valid, 1'b0);
    check("ra_tx_req", o_tx_req, 1'b0);
    wait_cyc(3);
    i_rst_n = 1'b1;
    wait_cyc(5);

    // recovery after reset
    rx0 = rx_pulses;
    i2c_start();
    write_byte(8'h84, ack);
    check("rec_addr_ack", ack, 1'b0);
    write_byte(8'h5A, ack);
    check("rec_data_ack", ack, 1'b0);
    i2c_stop();
    check("rec_rx_data", o_rx_data, 8'h5A);
    check("rec_rx_pulses", rx_pulses - rx0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
